// File: rtl/fpga_chan_pkg.sv
// Shared types and constants for the test-program output channel checker.
package fpga_chan_pkg;

    typedef enum logic [1:0] {
        CHK_RUN,
        CHK_DRAIN,
        CHK_DONE
    } chk_state_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] NO_BAD = 16'hFFFF;

endpackage

// File: rtl/out_channel_checker_fifo.sv
// Small synchronous FIFO between the program engine and the compare logic.
// The head is read combinationally from storage, so a word written at one edge
// can be compared at the following edge.
module chan_fifo #(
    parameter int Width = 12,
    parameter int Depth = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [Width-1:0]         data_i,
    output logic [Width-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int PW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PW+1)'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Guard against pushing into a full or popping from an empty buffer.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointers wrap naturally because Depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the buffer.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Word storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/out_channel_checker.sv
// Consumer end of the test-program output channel: buffers pushed words and
// compares them in order against a loadable expected table, then reports
// finished/success with the count of compared words and the first bad index.
//
// Handshake: a word moves on a rising edge where out_valid && out_ready.
// out_ready depends only on registered state; a producer seeing out_ready low
// keeps out_valid and out_data stable until the word is taken.
module out_channel_checker #(
    parameter int MemoryElementWidth = 12,
    parameter int NOut               = 3,
    parameter int Depth              = 4,
    parameter int MaxCycles          = 1000,
    localparam int AW = (NOut > 1) ? $clog2(NOut) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          exp_we,
    input  logic [AW-1:0]                 exp_addr,
    input  logic [MemoryElementWidth-1:0] exp_data,
    input  logic                          out_valid,
    input  logic [MemoryElementWidth-1:0] out_data,
    output logic                          out_ready,
    input  logic                          prog_done,
    input  logic                          check_en,
    output logic                          finished,
    output logic                          success,
    output logic [15:0]                   received,
    output logic [15:0]                   first_bad
);

    import fpga_chan_pkg::*;

    localparam int CYC_W = $clog2(MaxCycles) + 1;
    localparam int FCW   = $clog2(Depth) + 1;

    chk_state_t                    state_q, state_d;
    logic [CYC_W-1:0]              cyc_q, cyc_d;
    logic                          timeout_q, timeout_d;
    logic [CNT_W-1:0]              received_q, received_d;
    logic [CNT_W-1:0]              first_bad_q, first_bad_d;
    logic [MemoryElementWidth-1:0] exp_q [NOut];
    logic [MemoryElementWidth-1:0] exp_word;
    logic [MemoryElementWidth-1:0] fifo_head;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [FCW-1:0]                fifo_count;
    logic                          push;
    logic                          pop;
    logic                          in_range;
    logic                          bad;

    assign out_ready = (state_q == CHK_RUN) && !fifo_full;
    assign push      = out_valid && out_ready;
    assign pop       = check_en && !fifo_empty && (state_q != CHK_DONE);

    chan_fifo #(
        .Width (MemoryElementWidth),
        .Depth (Depth)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (out_data),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Expected table: loadable at any time, deliberately untouched by reset.
    always_ff @(posedge clock) begin
        if (exp_we && (32'(exp_addr) < NOut)) begin
            exp_q[exp_addr] <= exp_data;
        end
    end

    // Look up the expected word only when the compare index is in range.
    always_comb begin
        in_range = (received_q < CNT_W'(NOut));
        exp_word = '0;
        if (in_range) begin
            exp_word = exp_q[received_q[AW-1:0]];
        end
        bad = pop && (!in_range || (fifo_head != exp_word));
    end

    // Result bookkeeping: saturating compare count and sticky first bad index.
    always_comb begin
        received_d  = received_q;
        first_bad_d = first_bad_q;
        if (pop) begin
            if (received_q != '1) begin
                received_d = received_q + 1'b1;
            end
            if (bad && (first_bad_q == NO_BAD)) begin
                first_bad_d = received_q;
            end
        end
    end

    // Next-state logic: timeout wins over prog_done in the same RUN cycle.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        timeout_d = timeout_q;
        case (state_q)
            CHK_RUN: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == CYC_W'(MaxCycles - 1)) begin
                    state_d   = CHK_DONE;
                    timeout_d = 1'b1;
                end else if (prog_done) begin
                    state_d = CHK_DRAIN;
                end
            end
            CHK_DRAIN: begin
                // No pushes here, so the buffer empties when the last word pops.
                if (fifo_empty || ((fifo_count == FCW'(1)) && pop)) begin
                    state_d = CHK_DONE;
                end
            end
            CHK_DONE: begin
                state_d = CHK_DONE;
            end
            default: begin
                state_d = CHK_RUN;
            end
        endcase
    end

    // State, cycle counter and result registers; reset clears all status.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= CHK_RUN;
            cyc_q       <= '0;
            timeout_q   <= 1'b0;
            received_q  <= '0;
            first_bad_q <= NO_BAD;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            timeout_q   <= timeout_d;
            received_q  <= received_d;
            first_bad_q <= first_bad_d;
        end
    end

    assign finished  = (state_q == CHK_DONE);
    assign success   = finished && (first_bad_q == NO_BAD) &&
                       (received_q == CNT_W'(NOut)) && !timeout_q;
    assign received  = received_q;
    assign first_bad = first_bad_q;

endmodule
